ahb_subordinate_memory: RTL and testbench

- Synthesizable AHB subordinate (responder) backing one address window with byte-addressable memory.
- Acts as the RTL end that the manager-side agent drives. Used as the DUT-side subordinate in AVIP loopback benches.
- Pipelined address/data phases, configurable wait states, two-cycle ERROR response, write strobes, read-after-write forwarding.

---
 rtl/ahb_subordinate_memory_pkg.sv | 64 ++++++
 rtl/ahb_subordinate_memory_if.sv | 31 +++
 rtl/ahb_subordinate_byte_ram.sv | 25 ++
 rtl/ahb_subordinate_memory.sv | 160 ++++++++++++++++
 tb/tb_ahb_subordinate_memory.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/ahb_subordinate_memory_pkg.sv
// Shared AHB enums, subordinate FSM states and byte-lane helper for the
// AHB subordinate memory.
package ahb_subordinate_memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } ahbTransferEnum;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } ahbRespEnum;

  typedef enum logic [2:0] {
    BYTE       = 3'd0,
    HALFWORD   = 3'd1,
    WORD       = 3'd2,
    DOUBLEWORD = 3'd3,
    LINE4      = 3'd4,
    LINE8      = 3'd5,
    LINE16     = 3'd6,
    LINE32     = 3'd7
  } ahbHsizeEnum;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } ahbBurstEnum;

  typedef enum logic [2:0] {
    IDLE_ST = 3'd0,
    WAIT_ST = 3'd1,
    DATA_ST = 3'd2,
    ERR1_ST = 3'd3,
    ERR2_ST = 3'd4
  } ahbSubordinateStateEnum;

  localparam int WAIT_CNT_W = 4;

  // Byte lanes touched by a transfer of 2**size bytes at byte offset offs
  // inside a bus word of (lane_hi+1) bytes. Assumes an aligned address.
  function automatic logic [7:0] lane_mask(input logic [2:0] offs,
                                           input logic [2:0] size,
                                           input logic [2:0] lane_hi);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << (offs & lane_hi);
  endfunction

endpackage

// File: rtl/ahb_subordinate_memory_if.sv
// AHB bus bundle between a manager and the subordinate memory.
interface ahb_subordinate_memory_if
  import ahb_subordinate_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      hselx;
  logic [ADDR_WIDTH-1:0]     haddr;
  ahbTransferEnum            htrans;
  logic                      hwrite;
  ahbHsizeEnum               hsize;
  ahbBurstEnum               hburst;
  logic [3:0]                hprot;
  logic [DATA_WIDTH-1:0]     hwdata;
  logic [DATA_WIDTH/8-1:0]   hwstrb;
  logic                      hready;
  logic                      hreadyout;
  ahbRespEnum                hresp;
  logic [DATA_WIDTH-1:0]     hrdata;

  modport master (
    output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_subordinate_byte_ram.sv
// Word-organized storage with per-byte write enables, synchronous write and
// combinational read. Contents are intentionally not reset.
module ahb_subordinate_byte_ram #(
  parameter int NB    = 4,
  parameter int IDX_W = 10,
  parameter int DEPTH = 2**IDX_W
) (
  input  logic              i_clk,
  input  logic [NB-1:0]     i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [NB*8-1:0]   i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [NB*8-1:0]   o_rdata
);
  logic [NB-1:0][7:0] r_mem [DEPTH];

  // Byte-granular write of the enabled lanes
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we[b]) r_mem[i_waddr][b] <= i_wdata[b*8 +: 8];
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ahb_subordinate_memory.sv
// AHB subordinate backing one address window with byte-addressable memory:
// pipelined address/data phases, optional wait states, two-cycle ERROR
// response, strobed writes and forwarding of a committing write into a read
// sampled on the same edge.
module ahb_subordinate_memory
  import ahb_subordinate_memory_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MEM_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] MIN_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR      = ADDR_WIDTH'(32'h0000_0FFF),
  parameter int                    WAIT_STATES   = 0
) (
  input logic                    hclk,
  input logic                    hreset,
  ahb_subordinate_memory_if.slave bus
);
  localparam int         NB      = DATA_WIDTH / 8;
  localparam int         LOG2_NB = $clog2(NB);
  localparam int         WIDX_W  = MEM_ADDR_BITS - LOG2_NB;
  localparam logic [2:0] LANE_HI = 3'(NB - 1);

  ahbSubordinateStateEnum r_state, w_next;
  logic [WAIT_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_write;
  logic [2:0]             r_size;
  logic                   r_err;
  logic [DATA_WIDTH-1:0]  r_hrdata;

  logic                  w_sample, w_err, w_misalign, w_oversize, w_can_sample;
  logic [ADDR_WIDTH:0]   w_lo_diff, w_hi_diff;
  logic                  w_rd_load;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [2:0]            w_rd_size;
  logic [7:0]            w_wmask8, w_rmask8;
  logic [NB-1:0]         w_we;
  logic [WIDX_W-1:0]     w_widx, w_ridx;
  logic [DATA_WIDTH-1:0] w_mem_rd, w_rd_word;
  logic                  w_unused;

  // Window check via borrow bits so a zero MIN_ADDR never yields a constant compare
  assign w_lo_diff  = {1'b0, bus.haddr} - {1'b0, MIN_ADDR};
  assign w_hi_diff  = {1'b0, MAX_ADDR} - {1'b0, bus.haddr};
  assign w_oversize = (bus.hsize > 3'(LOG2_NB));
  assign w_err      = w_lo_diff[ADDR_WIDTH] | w_hi_diff[ADDR_WIDTH] | w_misalign | w_oversize;

  // Alignment of haddr to the transfer size
  always_comb begin
    w_misalign = 1'b0;
    case (bus.hsize)
      BYTE:     w_misalign = 1'b0;
      HALFWORD: w_misalign = bus.haddr[0];
      WORD:     w_misalign = |bus.haddr[1:0];
      default:  w_misalign = |bus.haddr[2:0];
    endcase
  end

  // Address phases are only taken in states that end with hreadyout=1
  assign w_can_sample = (r_state == IDLE_ST) || (r_state == DATA_ST) || (r_state == ERR2_ST);
  assign w_sample     = bus.hselx & bus.hready & w_can_sample &
                        ((bus.htrans == NONSEQ) || (bus.htrans == SEQ));

  // Next state, wait counter and read-load control
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_rd_load = 1'b0;
    w_rd_addr = r_addr;
    w_rd_size = r_size;
    case (r_state)
      IDLE_ST, DATA_ST, ERR2_ST: begin
        w_next = IDLE_ST;
        if (w_sample) begin
          if (w_err) begin
            w_next = ERR1_ST;
          end else if (WAIT_STATES > 0) begin
            w_next    = WAIT_ST;
            w_cnt_nxt = WAIT_CNT_W'(WAIT_STATES - 1);
          end else begin
            w_next    = DATA_ST;
            w_rd_load = ~bus.hwrite;
            w_rd_addr = bus.haddr;
            w_rd_size = bus.hsize;
          end
        end
      end
      WAIT_ST: begin
        if (r_cnt == '0) begin
          w_next    = DATA_ST;
          w_rd_load = ~r_write;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ERR1_ST: w_next = ERR2_ST;
      default: w_next = IDLE_ST;
    endcase
  end

  assign bus.hreadyout = (r_state != WAIT_ST) && (r_state != ERR1_ST);
  assign bus.hresp     = ((r_state == ERR1_ST) || (r_state == ERR2_ST)) ? ERROR : OKAY;
  assign bus.hrdata    = r_hrdata;

  // Write lanes: strobes limited to the bytes the size/address actually cover
  assign w_wmask8 = lane_mask(r_addr[2:0], r_size, LANE_HI);
  assign w_we     = (r_state == DATA_ST && r_write && !r_err) ? (bus.hwstrb & w_wmask8[NB-1:0]) : '0;
  assign w_widx   = r_addr[MEM_ADDR_BITS-1:LOG2_NB];
  assign w_ridx   = w_rd_addr[MEM_ADDR_BITS-1:LOG2_NB];
  assign w_rmask8 = lane_mask(w_rd_addr[2:0], w_rd_size, LANE_HI);

  ahb_subordinate_byte_ram #(
    .NB    (NB),
    .IDX_W (WIDX_W)
  ) u_ram (
    .i_clk   (hclk),
    .i_we    (w_we),
    .i_waddr (w_widx),
    .i_wdata (bus.hwdata),
    .i_raddr (w_ridx),
    .o_rdata (w_mem_rd)
  );

  // Read word: merge lanes committing this edge, then zero lanes outside the size
  always_comb begin
    w_rd_word = w_mem_rd;
    for (int b = 0; b < NB; b++) begin
      if (w_we[b] && (w_ridx == w_widx)) w_rd_word[b*8 +: 8] = bus.hwdata[b*8 +: 8];
      if (!w_rmask8[b]) w_rd_word[b*8 +: 8] = 8'h00;
    end
  end

  // FSM state, address-phase capture and registered read data
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= IDLE_ST;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_err    <= 1'b0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_sample) begin
        r_addr  <= bus.haddr;
        r_write <= bus.hwrite;
        r_size  <= bus.hsize;
        r_err   <= w_err;
      end
      if (w_next == ERR1_ST)  r_hrdata <= '0;
      else if (w_rd_load)     r_hrdata <= w_rd_word;
    end
  end

  assign w_unused = ^{bus.hburst, bus.hprot, r_addr, w_rd_addr, w_lo_diff, w_hi_diff,
                      w_wmask8, w_rmask8};
endmodule

// File: tb/tb_ahb_subordinate_memory.sv
// Directed bench: one subordinate with zero wait states and one with two,
// sharing a single manager drive selected by m_sel.
module tb_ahb_subordinate_memory;
  import ahb_subordinate_memory_pkg::*;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  logic           m_sel    = 1'b0;
  ahbTransferEnum m_htrans = IDLE;
  logic [31:0]    m_haddr  = '0;
  logic           m_hwrite = 1'b0;
  ahbHsizeEnum    m_hsize  = WORD;
  logic [31:0]    m_hwdata = '0;
  logic [3:0]     m_hwstrb = '0;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_subordinate_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahb_subordinate_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  assign bus0.hselx  = ~m_sel;
  assign bus0.haddr  = m_haddr;
  assign bus0.htrans = m_htrans;
  assign bus0.hwrite = m_hwrite;
  assign bus0.hsize  = m_hsize;
  assign bus0.hburst = SINGLE;
  assign bus0.hprot  = 4'h3;
  assign bus0.hwdata = m_hwdata;
  assign bus0.hwstrb = m_hwstrb;
  assign bus0.hready = bus0.hreadyout;

  assign bus2.hselx  = m_sel;
  assign bus2.haddr  = m_haddr;
  assign bus2.htrans = m_htrans;
  assign bus2.hwrite = m_hwrite;
  assign bus2.hsize  = m_hsize;
  assign bus2.hburst = SINGLE;
  assign bus2.hprot  = 4'h3;
  assign bus2.hwdata = m_hwdata;
  assign bus2.hwstrb = m_hwstrb;
  assign bus2.hready = bus2.hreadyout;

  ahb_subordinate_memory #(.WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
  ahb_subordinate_memory #(.WAIT_STATES(2)) dut2 (.hclk(hclk), .hreset(hreset), .bus(bus2));

  logic [31:0] o_rdy, o_resp, o_rdata;
  assign o_rdy   = {31'd0, (m_sel ? bus2.hreadyout : bus0.hreadyout)};
  assign o_resp  = {31'd0, (m_sel ? bus2.hresp : bus0.hresp)};
  assign o_rdata = m_sel ? bus2.hrdata : bus0.hrdata;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, return at the falling edge
  task automatic cyc(input ahbTransferEnum tr, input logic [31:0] a, input logic w,
                     input ahbHsizeEnum sz, input logic [31:0] wd, input logic [3:0] st);
    @(posedge hclk);
    #1;
    m_htrans = tr; m_haddr = a; m_hwrite = w; m_hsize = sz; m_hwdata = wd; m_hwstrb = st;
    @(negedge hclk);
  endtask

  initial begin
    // reset values on both subordinates
    @(negedge hclk);
    cmp("rst0_rdy", o_rdy, 1);  cmp("rst0_resp", o_resp, 0);  cmp("rst0_rdata", o_rdata, 0);
    m_sel = 1'b1; #1;
    cmp("rst2_rdy", o_rdy, 1);  cmp("rst2_resp", o_resp, 0);
    m_sel = 1'b0;
    hreset = 1'b0;

    // zero-wait write 0x10 then read 0x10
    cyc(NONSEQ, 32'h10, 1'b1, WORD, 32'h0, 4'h0);          cmp("t1_a_rdy", o_rdy, 1);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'hDEADBEEF, 4'hF);   cmp("t1_wd_rdy", o_rdy, 1); cmp("t1_wd_resp", o_resp, 0);
    cyc(NONSEQ, 32'h10, 1'b0, WORD, 32'h0, 4'h0);          cmp("t1_ra_rdy", o_rdy, 1);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t1_rd_rdy", o_rdy, 1); cmp("t1_rd_resp", o_resp, 0);
    cmp("t1_rdata", o_rdata, 32'hDEADBEEF);

    // write 0x40 immediately followed by read 0x40 (forwarded), then IDLE/BUSY
    cyc(NONSEQ, 32'h40, 1'b1, WORD, 32'h0, 4'h0);
    cyc(NONSEQ, 32'h40, 1'b0, WORD, 32'hCAFEF00D, 4'hF);   cmp("t5_wd_rdy", o_rdy, 1);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t5_rd_rdy", o_rdy, 1);
    cmp("t5_fwd_rdata", o_rdata, 32'hCAFEF00D);
    cyc(BUSY,   32'h44, 1'b0, WORD, 32'h0, 4'h0);          cmp("t5_busy_rdy", o_rdy, 1); cmp("t5_busy_resp", o_resp, 0);
    cyc(IDLE,   32'h44, 1'b0, WORD, 32'h0, 4'h0);          cmp("t5_idle_rdy", o_rdy, 1);
    cmp("t5_hold_rdata", o_rdata, 32'hCAFEF00D);

    // word write, halfword strobed write, word read (forwarded), byte read
    cyc(NONSEQ, 32'h30, 1'b1, WORD,     32'h0, 4'h0);
    cyc(NONSEQ, 32'h32, 1'b1, HALFWORD, 32'h11223344, 4'hF);
    cyc(NONSEQ, 32'h30, 1'b0, WORD,     32'hAABB0000, 4'hC);
    cyc(NONSEQ, 32'h31, 1'b0, BYTE,     32'h0, 4'h0);      cmp("t3_word_rdata", o_rdata, 32'hAABB3344);
    cyc(IDLE,   32'h0,  1'b0, WORD,     32'h0, 4'h0);      cmp("t3_byte_rdata", o_rdata, 32'h00003300);

    // errors: out-of-range write and misaligned read; 0x000 must survive
    cyc(NONSEQ, 32'h000, 1'b1, WORD, 32'h0, 4'h0);
    cyc(IDLE,   32'h0,   1'b0, WORD, 32'h5A5A1234, 4'hF);
    cyc(NONSEQ, 32'h1000, 1'b1, WORD, 32'h0, 4'h0);        cmp("t4_a_resp", o_resp, 0);
    cyc(IDLE,   32'h0,   1'b0, WORD, 32'hFFFFFFFF, 4'hF);  cmp("t4_e1_rdy", o_rdy, 0); cmp("t4_e1_resp", o_resp, 1);
    cmp("t4_e1_rdata", o_rdata, 0);
    cyc(IDLE,   32'h0,   1'b0, WORD, 32'h0, 4'h0);         cmp("t4_e2_rdy", o_rdy, 1); cmp("t4_e2_resp", o_resp, 1);
    cyc(NONSEQ, 32'h002, 1'b0, WORD, 32'h0, 4'h0);         cmp("t4_m_rdy", o_rdy, 1); cmp("t4_m_resp", o_resp, 0);
    cyc(IDLE,   32'h0,   1'b0, WORD, 32'h0, 4'h0);         cmp("t4_m1_rdy", o_rdy, 0); cmp("t4_m1_resp", o_resp, 1);
    cyc(IDLE,   32'h0,   1'b0, WORD, 32'h0, 4'h0);         cmp("t4_m2_rdy", o_rdy, 1); cmp("t4_m2_resp", o_resp, 1);
    cyc(NONSEQ, 32'h000, 1'b0, WORD, 32'h0, 4'h0);         cmp("t4_r_resp", o_resp, 0);
    cyc(IDLE,   32'h0,   1'b0, WORD, 32'h0, 4'h0);         cmp("t4_mem0_rdata", o_rdata, 32'h5A5A1234);

    // two wait states: pipelined writes to 0x20/0x24
    m_sel = 1'b1;
    cyc(NONSEQ, 32'h20, 1'b1, WORD, 32'h0, 4'h0);          cmp("t2_wa_rdy", o_rdy, 1);
    cyc(NONSEQ, 32'h24, 1'b1, WORD, 32'h01020304, 4'hF);   cmp("t2_w1_rdy", o_rdy, 0);
    cyc(NONSEQ, 32'h24, 1'b1, WORD, 32'h01020304, 4'hF);   cmp("t2_w2_rdy", o_rdy, 0);
    cyc(NONSEQ, 32'h24, 1'b1, WORD, 32'h01020304, 4'hF);   cmp("t2_w3_rdy", o_rdy, 1);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h05060708, 4'hF);   cmp("t2_w4_rdy", o_rdy, 0);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h05060708, 4'hF);   cmp("t2_w5_rdy", o_rdy, 0);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h05060708, 4'hF);   cmp("t2_w6_rdy", o_rdy, 1);
    // back-to-back reads, each delayed two cycles
    cyc(NONSEQ, 32'h20, 1'b0, WORD, 32'h0, 4'h0);          cmp("t2_ra_rdy", o_rdy, 1);
    cyc(NONSEQ, 32'h24, 1'b0, WORD, 32'h0, 4'h0);          cmp("t2_r1_rdy", o_rdy, 0);
    cyc(NONSEQ, 32'h24, 1'b0, WORD, 32'h0, 4'h0);          cmp("t2_r2_rdy", o_rdy, 0);
    cyc(NONSEQ, 32'h24, 1'b0, WORD, 32'h0, 4'h0);          cmp("t2_r3_rdy", o_rdy, 1);
    cmp("t2_rdata20", o_rdata, 32'h01020304);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t2_r4_rdy", o_rdy, 0);
    cmp("t2_hold_rdata", o_rdata, 32'h01020304);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t2_r5_rdy", o_rdy, 0);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t2_r6_rdy", o_rdy, 1);
    cmp("t2_rdata24", o_rdata, 32'h05060708);

    // reset in the wait phase of a write discards it
    cyc(NONSEQ, 32'h50, 1'b1, WORD, 32'h0, 4'h0);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h13572468, 4'hF);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h13572468, 4'hF);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h13572468, 4'hF);
    cyc(NONSEQ, 32'h50, 1'b1, WORD, 32'h0, 4'h0);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'hFFFFFFFF, 4'hF);   cmp("t6_wait_rdy", o_rdy, 0);
    #2 hreset = 1'b1;
    #1;
    cmp("t6_arst_rdy", o_rdy, 1);  cmp("t6_arst_resp", o_resp, 0);  cmp("t6_arst_rdata", o_rdata, 0);
    @(negedge hclk);
    hreset = 1'b0;
    cyc(NONSEQ, 32'h50, 1'b0, WORD, 32'h0, 4'h0);          cmp("t6_ra_rdy", o_rdy, 1);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t6_r1_rdy", o_rdy, 0);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t6_r2_rdy", o_rdy, 0);
    cyc(IDLE,   32'h0,  1'b0, WORD, 32'h0, 4'h0);          cmp("t6_r3_rdy", o_rdy, 1);
    cmp("t6_rdata50", o_rdata, 32'h13572468);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
